seq_signed_divider: RTL

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

---
 rtl/div_pkg.sv | 18 +
 rtl/div_restore_step.sv | 29 ++
 rtl/seq_signed_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    // Default operand width in bits.
    localparam int DEFAULT_WIDTH = 32;

    // Fill bit for the quotient returned on a divide-by-zero (all ones).
    localparam logic DIV_ZERO_FILL = 1'b1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One unsigned restoring-division iteration: shift, trial-subtract, select.
// Purely combinational; the top level feeds it back through its registers.
module div_restore_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem_in,
    input  logic [N-1:0] quot_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic [N-1:0] quot_out
);

    logic [N:0] shifted;
    logic [N:0] trial;

    // Shift the next dividend bit in, try the subtraction, keep it if it did not go negative.
    always_comb begin
        shifted = {rem_in[N-1:0], quot_in[N-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[N]) begin
            rem_out  = trial;
            quot_out = {quot_in[N-2:0], 1'b1};
        end else begin
            rem_out  = shifted;
            quot_out = {quot_in[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: magnitudes are divided with one restoring step
// per cycle, then signs are reapplied. Quotient truncates toward zero and the
// remainder takes the sign of the dividend.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero
);

    localparam int CW = $clog2(N) + 1;

    state_t          state_reg;
    logic [N:0]      rem_reg;
    logic [N-1:0]    quot_reg;
    logic [N-1:0]    divisor_reg;
    logic [CW-1:0]   count_reg;
    logic            q_sign_reg;
    logic            r_sign_reg;
    logic            zero_div_reg;

    logic [N-1:0]    quotient_reg;
    logic [N-1:0]    remainder_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            div_by_zero_reg;

    logic [N:0]      rem_next;
    logic [N-1:0]    quot_next;
    logic [N-1:0]    dividend_abs;
    logic [N-1:0]    divisor_abs;
    logic [N-1:0]    quot_fixed;
    logic [N-1:0]    rem_fixed;

    assign Quotient  = quotient_reg;
    assign Remainder = remainder_reg;
    assign Busy      = busy_reg;
    assign Done      = done_reg;
    assign DivByZero = div_by_zero_reg;

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // its correct unsigned magnitude.
    always_comb begin
        dividend_abs = Dividend[N-1] ? (-Dividend) : Dividend;
        divisor_abs  = Divisor[N-1]  ? (-Divisor)  : Divisor;
    end

    div_restore_step #(
        .N (N)
    ) u_step (
        .rem_in   (rem_reg),
        .quot_in  (quot_reg),
        .divisor  (divisor_reg),
        .rem_out  (rem_next),
        .quot_out (quot_next)
    );

    // Sign fix-up of the magnitudes; wrap modulo 2^N covers the MIN / -1 case.
    // For divide-by-zero the remainder register holds |Dividend|, so the same
    // negation restores the original dividend.
    always_comb begin
        quot_fixed = q_sign_reg ? (-quot_reg) : quot_reg;
        rem_fixed  = r_sign_reg ? (-rem_reg[N-1:0]) : rem_reg[N-1:0];
        if (zero_div_reg) begin
            quot_fixed = {N{DIV_ZERO_FILL}};
        end
    end

    // Controller and datapath registers with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rem_reg         <= '0;
            quot_reg        <= '0;
            divisor_reg     <= '0;
            count_reg       <= '0;
            q_sign_reg      <= 1'b0;
            r_sign_reg      <= 1'b0;
            zero_div_reg    <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        q_sign_reg  <= Dividend[N-1] ^ Divisor[N-1];
                        r_sign_reg  <= Dividend[N-1];
                        divisor_reg <= divisor_abs;
                        count_reg   <= '0;
                        busy_reg    <= 1'b1;
                        if (Divisor == '0) begin
                            zero_div_reg <= 1'b1;
                            quot_reg     <= '0;
                            rem_reg      <= {1'b0, dividend_abs};
                            state_reg    <= FIXUP;
                        end else begin
                            zero_div_reg <= 1'b0;
                            quot_reg     <= dividend_abs;
                            rem_reg      <= '0;
                            state_reg    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg   <= rem_next;
                    quot_reg  <= quot_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(N - 1)) begin
                        state_reg <= FIXUP;
                    end
                end
                FIXUP: begin
                    quotient_reg    <= quot_fixed;
                    remainder_reg   <= rem_fixed;
                    div_by_zero_reg <= zero_div_reg;
                    done_reg        <= 1'b1;
                    state_reg       <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
